vram_arbiter: RTL

//  Shares one single-port 32-bit VRAM (4 bit-planes x 8K words) between CPU byte writes and the

---
 rtl/vram_arbiter_if.sv | 34 +++
 rtl/vram_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: CPU write port, video read port and the VRAM port.
// The arbiter connects through the slave modport; the CPU/video/VRAM side uses master.
interface vram_arbiter_if;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_we;
   logic        cpu_wait;
   logic        cpu_ovf;

   logic        vid_req;
   logic [12:0] vid_addr;
   logic        vid_ack;
   logic [31:0] vid_data;
   logic        vid_valid;

   logic [12:0] mem_addr;
   logic [31:0] mem_din;
   logic [3:0]  mem_be;
   logic        mem_we;
   logic        mem_rd;
   logic [31:0] mem_q;

   modport slave (
      input  cpu_addr, cpu_din, cpu_we, vid_req, vid_addr, mem_q,
      output cpu_wait, cpu_ovf, vid_ack, vid_data, vid_valid,
             mem_addr, mem_din, mem_be, mem_we, mem_rd
   );

   modport master (
      output cpu_addr, cpu_din, cpu_we, vid_req, vid_addr, mem_q,
      input  cpu_wait, cpu_ovf, vid_ack, vid_data, vid_valid,
             mem_addr, mem_din, mem_be, mem_we, mem_rd
   );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 32-bit VRAM between queued CPU byte writes and video reads.
// Optional build macro VRAM_ARB_COHERENT_EN: video reads wait for queued writes to the same word.
module vram_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LAT     = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic          clk_sys,
   input  logic          reset,
   vram_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);

   localparam logic [1:0] GNT_IDLE = 2'd0;
   localparam logic [1:0] GNT_VID  = 2'd1;
   localparam logic [1:0] GNT_CPU  = 2'd2;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   wr_entry_t         fifo_q [FIFO_DEPTH];
   wr_entry_t         fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              vid_ack_q, vid_ack_d;
   logic              cpu_wait_q, cpu_wait_d;
   logic              cpu_ovf_q, cpu_ovf_d;
   logic [12:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_din_q, mem_din_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_rd_q, mem_rd_d;
   logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
   logic [RD_LAT:0]   rd_tag;

   logic              fifo_nonempty;
   logic              fifo_full;
   logic              starved;
   logic              vid_eligible;
   logic [1:0]        grant;
   logic              push;
   logic              pop;
   logic              drop;
   wr_entry_t         head;
   logic              vid_valid;

   always_comb begin
      fifo_nonempty = (count_q != '0);
      fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
      head          = fifo_q[rd_ptr_q];
      starved       = fifo_nonempty && (starve_q == STV_W'(STARVE_MAX));
      vid_eligible  = bus.vid_req && !vid_ack_q;
   end

`ifdef VRAM_ARB_COHERENT_EN
   logic [FIFO_DEPTH-1:0] entry_hit;
   logic                  coh_drain;

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         entry_hit[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q) &&
                        (fifo_q[i].addr[12:0] == bus.vid_addr);
      end
      coh_drain = vid_eligible && (|entry_hit);
   end
`endif

   always_comb begin
      grant = GNT_IDLE;
      if (vid_eligible && !starved) begin
         grant = GNT_VID;
      end else if (fifo_nonempty) begin
         grant = GNT_CPU;
      end
`ifdef VRAM_ARB_COHERENT_EN
      // A queued write to the requested word lands first, regardless of the starve state.
      if (coh_drain) begin
         grant = GNT_CPU;
      end
`endif
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      mem_rd_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      mem_din_d  = '0;
      mem_be_d   = '0;
      vid_ack_d  = 1'b0;
      starve_d   = starve_q;
      pop        = 1'b0;

      case (grant)
         GNT_VID: begin
            mem_rd_d   = 1'b1;
            mem_addr_d = bus.vid_addr;
            vid_ack_d  = 1'b1;
            if (!fifo_nonempty) begin
               starve_d = '0;
            end else if (starve_q != STV_W'(STARVE_MAX)) begin
               starve_d = starve_q + STV_W'(1);
            end
         end
         GNT_CPU: begin
            pop        = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = head.addr[12:0];
            mem_be_d   = 4'b0001 << head.addr[14:13];
            mem_din_d  = {4{head.data}};
`ifdef VRAM_ARB_COHERENT_EN
            if (!coh_drain) begin
               starve_d = '0;
            end
`else
            starve_d   = '0;
`endif
         end
         default: ;
      endcase

      // A full queue still accepts a write in the cycle its head is popped.
      push = bus.cpu_we && (!fifo_full || pop);
      drop = bus.cpu_we && !push;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: ;
      endcase

      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

      fifo_d = fifo_q;
      if (push) begin
         fifo_d[wr_ptr_q] = {bus.cpu_addr, bus.cpu_din};
      end

      cpu_wait_d = (count_d == CNT_W'(FIFO_DEPTH));
      cpu_ovf_d  = cpu_ovf_q || drop;

      rd_tag    = {rd_pipe_q, mem_rd_q};
      rd_pipe_d = rd_tag[RD_LAT-1:0];
   end

   // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         vid_ack_q  <= 1'b0;
         cpu_wait_q <= 1'b0;
         cpu_ovf_q  <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_be_q   <= '0;
         mem_we_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         rd_pipe_q  <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         vid_ack_q  <= vid_ack_d;
         cpu_wait_q <= cpu_wait_d;
         cpu_ovf_q  <= cpu_ovf_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_be_q   <= mem_be_d;
         mem_we_q   <= mem_we_d;
         mem_rd_q   <= mem_rd_d;
         rd_pipe_q  <= rd_pipe_d;
      end
   end

   // NOTE: queue storage has no reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk_sys) begin
      fifo_q <= fifo_d;
   end

   assign vid_valid = rd_pipe_q[RD_LAT-1];

   assign bus.cpu_wait  = cpu_wait_q;
   assign bus.cpu_ovf   = cpu_ovf_q;
   assign bus.vid_ack   = vid_ack_q;
   assign bus.vid_valid = vid_valid;
   assign bus.vid_data  = vid_valid ? bus.mem_q : '0;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_din   = mem_din_q;
   assign bus.mem_be    = mem_be_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_rd    = mem_rd_q;

endmodule
